// File: rtl/hnm_controller_pkg.sv
// rtl/hnm_controller_pkg.sv - shared HNM sizing constants and controller FSM encoding
package hnm_controller_pkg;

    localparam int NROWS_HNM = 256;
    localparam int SSID_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_DUMP  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } hnm_state_e;

endpackage

// File: rtl/hnm_rr_arbiter.sv
// rtl/hnm_rr_arbiter.sv - combinational round-robin arbiter, search starts after last winner
module hnm_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     grant_o
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDX_W'((int'(last_i) + k) % N);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hnm_controller.sv
// rtl/hnm_controller.sv - HNM access controller: write/read arbitration and end-of-event dump-and-clear sweep
module hnm_controller
    import hnm_controller_pkg::*;
#(
    parameter int N_WR = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_WR-1:0]        wr_req,
    input  logic [N_WR*SSID_W-1:0] wr_ssid,
    output logic [N_WR-1:0]        wr_grant,
    input  logic                   rd_req,
    input  logic [SSID_W-1:0]      rd_ssid,
    output logic                   rd_grant,
    input  logic                   clear_req,
    input  logic                   HNM_writeReady,
    input  logic                   HNM_readReady,
    output logic                   write,
    output logic [SSID_W-1:0]      SSID_write,
    output logic                   read,
    output logic [SSID_W-1:0]      SSID_read,
    output logic                   HNM_reset,
    output logic                   dump_active,
    output logic                   clear_done
);

    localparam int IDX_W = (N_WR > 1) ? $clog2(N_WR) : 1;

    hnm_state_e       state_q;
    logic [SSID_W-1:0] row_q;
    logic [IDX_W-1:0] last_q, last_d;
    logic             write_q, read_q, hnm_reset_q, dump_active_q, clear_done_q;
    logic [SSID_W-1:0] ssid_write_q, ssid_read_q, ssid_sel;
    logic             idle, wr_en, any_grant;
    logic [N_WR-1:0]  arb_req, arb_grant;

    // Grants are only ever live in IDLE and out of reset.
    assign idle     = (state_q == ST_IDLE);
    assign wr_en    = reset & idle & HNM_writeReady;
    assign arb_req  = wr_req & {N_WR{wr_en}};
    assign wr_grant = arb_grant;
    assign rd_grant = reset & idle & rd_req & HNM_readReady;
    assign any_grant = |arb_grant;

    hnm_rr_arbiter #(.N(N_WR), .IDX_W(IDX_W)) u_arb (
        .req_i   (arb_req),
        .last_i  (last_q),
        .grant_o (arb_grant)
    );

    always_comb begin
        last_d   = last_q;
        ssid_sel = '0;
        for (int i = 0; i < N_WR; i++) begin
            if (arb_grant[i]) begin
                last_d   = IDX_W'(i);
                ssid_sel = wr_ssid[i*SSID_W +: SSID_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            last_q        <= IDX_W'(N_WR - 1);
            write_q       <= 1'b0;
            ssid_write_q  <= '0;
            read_q        <= 1'b0;
            ssid_read_q   <= '0;
            hnm_reset_q   <= 1'b0;
            dump_active_q <= 1'b0;
            clear_done_q  <= 1'b0;
        end else begin
            write_q      <= any_grant;
            last_q       <= last_d;
            read_q       <= 1'b0;
            hnm_reset_q  <= 1'b0;
            clear_done_q <= 1'b0;
            if (any_grant) begin
                ssid_write_q <= ssid_sel;
            end
            case (state_q)
                ST_IDLE: begin
                    read_q <= rd_grant;
                    if (rd_grant) begin
                        ssid_read_q <= rd_ssid;
                    end
                    if (clear_req) begin
                        state_q       <= ST_DRAIN;
                        dump_active_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DUMP;
                    row_q   <= '0;
                end
                ST_DUMP: begin
                    // Row advances only when the HNM accepts the read, so stalls never skip rows.
                    if (HNM_readReady) begin
                        read_q      <= 1'b1;
                        ssid_read_q <= row_q;
                        if (row_q == SSID_W'(NROWS_HNM - 1)) begin
                            row_q       <= '0;
                            state_q     <= ST_CLEAR;
                            hnm_reset_q <= 1'b1;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    state_q      <= ST_DONE;
                    clear_done_q <= 1'b1;
                end
                ST_DONE: begin
                    state_q       <= ST_IDLE;
                    dump_active_q <= 1'b0;
                end
                default: begin
                    state_q       <= ST_IDLE;
                    dump_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign write       = write_q;
    assign SSID_write  = ssid_write_q;
    assign read        = read_q;
    assign SSID_read   = ssid_read_q;
    assign HNM_reset   = hnm_reset_q;
    assign dump_active = dump_active_q;
    assign clear_done  = clear_done_q;

endmodule

// File: tb/tb_hnm_controller.sv
// tb/tb_hnm_controller.sv - directed vector bench for hnm_controller
module tb_hnm_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  wr_req;
    logic [31:0] wr_ssid;
    logic [3:0]  wr_grant;
    logic        rd_req;
    logic [7:0]  rd_ssid;
    logic        rd_grant;
    logic        clear_req;
    logic        HNM_writeReady;
    logic        HNM_readReady;
    logic        write;
    logic [7:0]  SSID_write;
    logic        read;
    logic [7:0]  SSID_read;
    logic        HNM_reset;
    logic        dump_active;
    logic        clear_done;

    int n_checks = 0;
    int n_errors = 0;

    hnm_controller #(.N_WR(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_req         (wr_req),
        .wr_ssid        (wr_ssid),
        .wr_grant       (wr_grant),
        .rd_req         (rd_req),
        .rd_ssid        (rd_ssid),
        .rd_grant       (rd_grant),
        .clear_req      (clear_req),
        .HNM_writeReady (HNM_writeReady),
        .HNM_readReady  (HNM_readReady),
        .write          (write),
        .SSID_write     (SSID_write),
        .read           (read),
        .SSID_read      (SSID_read),
        .HNM_reset      (HNM_reset),
        .dump_active    (dump_active),
        .clear_done     (clear_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic [3:0] wr_req;
        logic       wr_rdy;
        logic       rd_req;
        logic [7:0] rd_ssid;
        logic       rd_rdy;
        logic [3:0] e_wg;
        logic       e_rg;
        logic       e_w;
        logic [7:0] e_sw;
        logic       e_r;
        logic [7:0] e_sr;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic sweep(input int stall_k, input int rst_k);
        int end_k, row, grant_err, order_err, act_err, stall_err, hr_cnt, hr_k, cd_cnt, cd_k;
        end_k = (rst_k != 0) ? rst_k : 259 + ((stall_k != 0) ? 5 : 0);
        row = 0; grant_err = 0; order_err = 0; act_err = 0; stall_err = 0;
        hr_cnt = 0; hr_k = 0; cd_cnt = 0; cd_k = 0;
        wr_req = 4'b0001; HNM_writeReady = 1'b1; HNM_readReady = 1'b1;
        rd_req = 1'b0; clear_req = 1'b1;
        #1;
        chk("clear cycle wr_grant", wr_grant, 4'b0001);
        for (int k = 1; k <= end_k + 8; k++) begin
            @(posedge clk);
            #1;
            clear_req     = (rst_k == 0 && k == 100);
            reset         = !(rst_k != 0 && k == rst_k);
            HNM_readReady = !(stall_k != 0 && k >= stall_k && k < stall_k + 5);
            rd_req        = 1'b1;
            rd_ssid       = 8'h55;
            wr_req        = 4'b0001;
            #1;
            if (k == 1) chk("write from clear cycle grant", write, 1);
            if (k <= end_k) begin
                if (wr_grant != 4'b0000 || rd_grant != 1'b0) grant_err++;
                if (k >= 2 && write) grant_err++;
                if (read) begin
                    if (SSID_read !== 8'(row)) order_err++;
                    row++;
                end
                if (stall_k != 0 && k > stall_k && k <= stall_k + 5 && read) stall_err++;
            end
            if (dump_active !== (k <= end_k)) act_err++;
            if (HNM_reset) begin hr_cnt++; hr_k = k; end
            if (clear_done) begin cd_cnt++; cd_k = k; end
            if (rst_k != 0 && k == rst_k + 1) begin
                chk("abort write", write, 0);
                chk("abort SSID_write", SSID_write, 0);
                chk("abort read", read, 0);
                chk("abort SSID_read", SSID_read, 0);
                chk("abort dump_active", dump_active, 0);
                chk("abort wr_grant restart", wr_grant, 4'b0001);
            end
        end
        clear_req = 1'b0;
        rd_req    = 1'b0;
        wr_req    = 4'b0000;
        HNM_readReady = 1'b1;
        chk("sweep read count", row, (rst_k != 0) ? 50 : 256);
        chk("sweep read order", order_err, 0);
        chk("sweep grants blocked", grant_err, 0);
        chk("sweep dump_active profile", act_err, 0);
        chk("sweep HNM_reset count", hr_cnt, (rst_k != 0) ? 0 : 1);
        chk("sweep clear_done count", cd_cnt, (rst_k != 0) ? 0 : 1);
        if (rst_k == 0) begin
            chk("sweep HNM_reset cycle", hr_k, end_k - 1);
            chk("sweep clear_done cycle", cd_k, end_k);
        end
        if (stall_k != 0) chk("stall no read", stall_err, 0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 8'h00, 1'b1, 4'b0001, 1'b0, 1'b1, 8'd10, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 8'h00, 1'b1, 4'b0010, 1'b0, 1'b1, 8'd11, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 8'h00, 1'b1, 4'b0100, 1'b0, 1'b1, 8'd12, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 8'h00, 1'b1, 4'b1000, 1'b0, 1'b1, 8'd13, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 8'h00, 1'b1, 4'b0001, 1'b0, 1'b1, 8'd10, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 4'b0010, 1'b1, 1'b1, 8'h3C, 1'b1, 4'b0010, 1'b1, 1'b1, 8'd11, 1'b1, 8'h3C};
        vecs[6]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 8'h77, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd0,  1'b0, 8'h00};
        vecs[7]  = '{1'b0, 4'b1000, 1'b0, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd0,  1'b0, 8'h00};
        vecs[8]  = '{1'b1, 4'b0101, 1'b0, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd0,  1'b0, 8'h00};
        vecs[9]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd0,  1'b0, 8'h00};
        vecs[10] = '{1'b0, 4'b0101, 1'b0, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd0,  1'b0, 8'h00};
        vecs[11] = '{1'b0, 4'b0101, 1'b1, 1'b0, 8'h00, 1'b1, 4'b0001, 1'b0, 1'b1, 8'd10, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 4'b0101, 1'b1, 1'b0, 8'h00, 1'b1, 4'b0100, 1'b0, 1'b1, 8'd12, 1'b0, 8'h00};
        vecs[13] = '{1'b0, 4'b0101, 1'b1, 1'b0, 8'h00, 1'b1, 4'b0001, 1'b0, 1'b1, 8'd10, 1'b0, 8'h00};

        reset = 1'b0; wr_req = 4'b0000; wr_ssid = {8'd13, 8'd12, 8'd11, 8'd10};
        rd_req = 1'b0; rd_ssid = 8'h00; clear_req = 1'b0;
        HNM_writeReady = 1'b0; HNM_readReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wr_req = 4'b1111; rd_req = 1'b1; HNM_writeReady = 1'b1; HNM_readReady = 1'b1;
        #1;
        chk("reset wr_grant", wr_grant, 0);
        chk("reset rd_grant", rd_grant, 0);
        @(posedge clk);
        #1;
        chk("reset write", write, 0);
        chk("reset read", read, 0);
        chk("reset SSID_write", SSID_write, 0);
        chk("reset SSID_read", SSID_read, 0);
        chk("reset HNM_reset", HNM_reset, 0);
        chk("reset dump_active", dump_active, 0);
        chk("reset clear_done", clear_done, 0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst) apply_reset();
            wr_req         = vecs[i].wr_req;
            HNM_writeReady = vecs[i].wr_rdy;
            rd_req         = vecs[i].rd_req;
            rd_ssid        = vecs[i].rd_ssid;
            HNM_readReady  = vecs[i].rd_rdy;
            #1;
            chk($sformatf("v%0d wr_grant", i), wr_grant, vecs[i].e_wg);
            chk($sformatf("v%0d rd_grant", i), rd_grant, vecs[i].e_rg);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d write", i), write, vecs[i].e_w);
            if (vecs[i].e_w) chk($sformatf("v%0d SSID_write", i), SSID_write, vecs[i].e_sw);
            chk($sformatf("v%0d read", i), read, vecs[i].e_r);
            if (vecs[i].e_r) chk($sformatf("v%0d SSID_read", i), SSID_read, vecs[i].e_sr);
        end

        sweep(0, 0);
        sweep(102, 0);
        sweep(0, 52);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hnm_controller.md
HNM_CONTROLLER -- requirements
Module: hnm_controller

Interface
REQ-001 SHALL have parameter N_WR, default 4: number of write requesters.
REQ-002 SHALL have parameter NROWS_HNM, default 256, from shared package: HNM rows; SSID width SSID_W = 8.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port wr_req  input  N_WR  per-requester write request, held until granted.
REQ-006 SHALL have port wr_ssid  input  N_WR*SSID_W  per-requester SSID; slice i belongs to requester i.
REQ-007 SHALL have port wr_grant  output  N_WR  one-hot combinational grant.
REQ-008 SHALL have port rd_req / rd_ssid / rd_grant  in/in/out  1/SSID_W/1  external read request, SSID, combinational grant.
REQ-009 SHALL have port clear_req  input  1  start end-of-event dump-and-clear sweep.
REQ-010 SHALL have port HNM_writeReady / HNM_readReady  input  1/1  HNM accept status.
REQ-011 SHALL have port write / SSID_write  output  1/SSID_W  registered HNM write strobe and address.
REQ-012 SHALL have port read / SSID_read  output  1/SSID_W  registered HNM read strobe and address.
REQ-013 SHALL have port HNM_reset  output  1  registered active-high clear pulse to HNM.
REQ-014 SHALL have port dump_active / clear_done  output  1/1  sweep-in-progress level; one-cycle done pulse.

Function
REQ-015 SHALL implement FSM states IDLE, DRAIN, DUMP, CLEAR, DONE.
REQ-016 IDLE: round-robin write arbitration; with HNM_writeReady=1 and any wr_req, SHALL assert exactly one wr_grant bit, searching from last_granted+1 modulo N_WR.
REQ-017 SHALL update last_granted only on a grant; last_granted = N_WR-1 after reset, so requester 0 wins first.
REQ-018 Granted at cycle t SHALL yield write=1, SSID_write=wr_ssid slice at t, in cycle t+1 (latency 1); no grant -> write=0 next cycle.
REQ-019 HNM_writeReady=0 SHALL force wr_grant=0.
REQ-020 IDLE: rd_grant = rd_req & HNM_readReady; read=1, SSID_read=rd_ssid in next cycle; reads and writes independent, same-cycle allowed.
REQ-021 IDLE and clear_req=1 SHALL go to DRAIN next cycle; that cycle's grants still issue.
REQ-022 DRAIN SHALL last exactly one cycle, all grants 0, then DUMP with row counter 0.
REQ-023 DUMP: each cycle HNM_readReady=1 SHALL issue read=1, SSID_read=counter next cycle, counter+1; HNM_readReady=0 SHALL hold counter, read=0.
REQ-024 After issuing row NROWS_HNM-1, counter SHALL wrap to 0 and FSM go to CLEAR; no row skipped or repeated.
REQ-025 CLEAR SHALL drive HNM_reset=1 for exactly one cycle, then DONE.
REQ-026 DONE SHALL drive clear_done=1 for one cycle, then IDLE.
REQ-027 dump_active SHALL be 1 in DRAIN, DUMP, CLEAR, DONE; 0 in IDLE.
REQ-028 Outside IDLE, wr_grant and rd_grant SHALL be 0; clear_req outside IDLE SHALL be ignored, not queued.

Reset
REQ-029 reset=0 at a clock edge SHALL force IDLE, counter 0, last_granted N_WR-1, write=read=HNM_reset=clear_done=0, SSID_write=SSID_read=0, dump_active=0.
REQ-030 Combinational grants SHALL be 0 while reset=0.
REQ-031 Reset mid-sweep SHALL abort without HNM_reset pulse or clear_done.

Structure
REQ-032 NROWS_HNM, SSID_W and FSM state encoding SHALL live in the shared package.
REQ-033 Round-robin arbiter SHALL be sub-module hnm_rr_arbiter (req, last pointer -> one-hot grant, combinational).

Verification
REQ-034 wr_req=4'b1111, ssids 10/11/12/13, held -> writes SSID 10,11,12,13,10 in consecutive cycles.
REQ-035 wr_req=4'b0101 with HNM_writeReady low 3 cycles -> no grants/writes in those cycles, then requester 0 then 2.
REQ-036 rd_req with rd_ssid=0x3C and write request same cycle -> next cycle read=1, SSID_read=0x3C and write=1.
REQ-037 clear_req in IDLE -> one DRAIN cycle, reads of SSIDs 0..255 in order, one HNM_reset pulse, clear_done pulse; total 259 cycles excluding stalls.
REQ-038 HNM_readReady low 5 cycles at row 100 of dump -> no read, SSID_read resumes at 100, no duplicates.
REQ-039 reset=0 at row 50 of dump -> IDLE next cycle, all outputs 0, no HNM_reset or clear_done.
